// File: rtl/burst_cache.sv
// Direct-mapped, write-back, write-allocate data cache between a 32-bit CPU word port
// and a 4-beat x 64-bit burst RAM. Hits complete combinationally; misses stall on busy.
module burst_cache #(
  parameter int LineIndexBitWidth  = 2,
  parameter int RamAddressBitWidth = 10,
  parameter int RamAddressingMode  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [31:0]                   address,
  output logic [31:0]                   data_out,
  output logic                          data_out_ready,
  input  logic [31:0]                   data_in,
  input  logic [3:0]                    write_enable,
  output logic                          busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RamAddressBitWidth-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid,
  output logic [2:0]                    dbg_state
);
  localparam int Lines = 1 << LineIndexBitWidth;
  localparam int TagLo = 5 + LineIndexBitWidth;
  localparam int TagHi = RamAddressBitWidth + RamAddressingMode - 1;
  localparam int TagW  = TagHi - TagLo + 1;

  typedef enum logic [2:0] {IDLE, WB_CMD, WB_DATA, RD_CMD, RD_WAIT, DONE} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   beat_q, beat_d;
  logic [Lines-1:0]             valid_q, dirty_q;
  logic [TagW-1:0]              tag_q [Lines];
  logic [31:0]                  data_q [Lines][8];

  logic [LineIndexBitWidth-1:0] idx;
  logic [2:0]                   word;
  logic [TagW-1:0]              tag_in;
  logic                         hit, write_hit, fill_beat, fill_last;
  logic                         unused_addr_bits;

  assign idx              = address[TagLo-1:5];
  assign word             = address[4:2];
  assign tag_in           = address[TagHi:TagLo];
  assign unused_addr_bits = ^{address[31:TagHi+1], address[1:0]};

  assign hit          = enable && valid_q[idx] && (tag_q[idx] == tag_in);
  assign write_hit    = rst_n && (state_q == IDLE) && hit && (write_enable != 4'b0000);
  assign fill_beat    = (state_q == RD_WAIT) && br_rd_data_valid;
  assign fill_last    = fill_beat && (beat_q == 2'd3);
  assign data_out     = data_q[idx][word];
  assign br_data_mask = 8'h00;
  assign dbg_state    = state_q;

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    busy           = 1'b0;
    data_out_ready = 1'b0;
    br_cmd         = 1'b0;
    br_cmd_en      = 1'b0;
    br_addr        = '0;
    br_wr_data     = '0;
    case (state_q)
      IDLE: begin
        if (enable && !hit) begin
          busy    = 1'b1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? WB_CMD : RD_CMD;
        end else if (hit) begin
          data_out_ready = (write_enable == 4'b0000);
        end
      end
      WB_CMD: begin
        busy       = 1'b1;
        br_cmd     = 1'b1;
        br_cmd_en  = 1'b1;
        br_addr    = {tag_q[idx], idx, 2'b00};
        br_wr_data = {data_q[idx][1], data_q[idx][0]};
        beat_d     = 2'd1;
        state_d    = WB_DATA;
      end
      WB_DATA: begin
        busy       = 1'b1;
        br_wr_data = {data_q[idx][{beat_q, 1'b1}], data_q[idx][{beat_q, 1'b0}]};
        beat_d     = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = RD_CMD;
      end
      RD_CMD: begin
        busy      = 1'b1;
        br_cmd_en = 1'b1;
        br_addr   = {tag_in, idx, 2'b00};
        beat_d    = 2'd0;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (br_rd_data_valid) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset silences the port immediately, even while inputs are still held.
    if (!rst_n) begin
      busy           = 1'b0;
      data_out_ready = 1'b0;
      br_cmd         = 1'b0;
      br_cmd_en      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (fill_last) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (write_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays keep their contents across reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_beat) begin
      data_q[idx][{beat_q, 1'b0}] <= br_rd_data[31:0];
      data_q[idx][{beat_q, 1'b1}] <= br_rd_data[63:32];
    end
    if (fill_last) tag_q[idx] <= tag_in;
    if (write_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (write_enable[b]) data_q[idx][word][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_burst_cache.sv
// Bench for burst_cache: burst RAM responder, flat word-memory reference and directed
// plus random accesses, each result checked with an immediate assertion.
module tb_burst_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic [31:0] data_in = '0;
  logic [3:0]  write_enable = '0;
  logic        busy;
  logic        br_cmd, br_cmd_en;
  logic [9:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data = '0;
  logic        br_rd_data_valid = 1'b0;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  burst_cache dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .address(address),
    .data_out(data_out), .data_out_ready(data_out_ready), .data_in(data_in),
    .write_enable(write_enable), .busy(busy), .br_cmd(br_cmd), .br_cmd_en(br_cmd_en),
    .br_addr(br_addr), .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .dbg_state(dbg_state)
  );

  // ---------------- burst RAM responder ----------------
  logic [63:0] ram [1024];
  logic        ram_ready = 1'b0;
  logic [10:0] cmd_log [$];
  int          cyc_log [$];
  int          cyc = 0;
  int          wr_left = 0, rd_left = 0, rd_wait = 0;
  logic [9:0]  wr_base = '0, rd_base = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    br_rd_data_valid <= 1'b0;
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= {$urandom(), $urandom()};
      ram_ready <= 1'b1;
    end
    if (br_cmd_en) begin
      cmd_log.push_back({br_cmd, br_addr});
      cyc_log.push_back(cyc);
      if (br_cmd) begin
        ram[br_addr] <= br_wr_data;
        wr_base <= br_addr;
        wr_left <= 3;
      end else begin
        rd_base <= br_addr;
        rd_wait <= 3;
        rd_left <= 4;
      end
    end
    if (wr_left > 0) begin
      ram[wr_base + 10'(4 - wr_left)] <= br_wr_data;
      wr_left <= wr_left - 1;
    end
    if (rd_left > 0) begin
      if (rd_wait > 0) rd_wait <= rd_wait - 1;
      else if ($urandom_range(0, 3) != 0) begin
        br_rd_data_valid <= 1'b1;
        br_rd_data <= ram[rd_base + 10'(4 - rd_left)];
        rd_left <= rd_left - 1;
      end
    end
  end

  // ---------------- reference: the cache is transparent over a 2048-word memory ----------------
  logic [31:0] ref_mem [2048];
  int compared = 0, mismatched = 0, timeouts = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sync_ref_from_ram();
    for (int w = 0; w < 2048; w++)
      ref_mem[w] = (w % 2 == 1) ? ram[w / 2][63:32] : ram[w / 2][31:0];
  endtask

  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        output logic [31:0] rd, output logic rdy, output int lat);
    @(negedge clk);
    enable = 1'b1; address = a; write_enable = we; data_in = wd; lat = 0;
    #1;
    while (busy && lat < 200) begin
      @(negedge clk); #1; lat++;
    end
    if (lat >= 200) timeouts++;
    rd = data_out;
    rdy = data_out_ready;
    @(posedge clk); #1;
    enable = 1'b0; write_enable = 4'b0000;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    logic [31:0] rd; logic rdy; int lat;
    access(a, we, wd, rd, rdy, lat);
    for (int b = 0; b < 4; b++)
      if (we[b]) ref_mem[a[12:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, output int lat);
    logic [31:0] rd; logic rdy;
    access(a, 4'b0000, 32'h0, rd, rdy, lat);
    check({tag, "_ready"}, 64'(rdy), 64'd1);
    check({tag, "_data"}, 64'(rd), 64'(ref_mem[a[12:2]]));
  endtask

  task automatic random_phase(input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [3:0]  we;
      a  = ($urandom() & 32'hffff_e000) | 32'(($urandom_range(0, 2047)) << 2);
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (we == 4'h0) rd_check("rand_rd", a, lat);
      else wr(a, we, $urandom());
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base, n_wb, n_rd, found;
    logic [31:0] rd; logic rdy;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(data_out_ready), 64'd0);
    check("reset_cmd_en", 64'(br_cmd_en), 64'd0);
    check("reset_cmd", 64'(br_cmd), 64'd0);
    check("reset_mask", 64'(br_data_mask), 64'd0);
    sync_ref_from_ram();
    @(negedge clk); rst_n = 1'b1;

    // fill 1024 words: 128 lines through 4 slots, every eviction after the first 4 is dirty
    base = cmd_log.size();
    for (int i = 0; i < 1024; i++) wr(32'(4 * i), 4'hf, 32'(i));
    check("fill_timeouts", 64'(timeouts), 64'd0);
    n_wb = 0; n_rd = 0;
    for (int k = base; k < cmd_log.size(); k++) begin
      if (cmd_log[k][10]) n_wb++; else n_rd++;
    end
    check("fill_wb_bursts", 64'(n_wb), 64'd124);
    check("fill_rd_bursts", 64'(n_rd), 64'd128);

    // read miss then same-line hit
    rd_check("rd4_miss", 32'h4, lat);
    check("rd4_was_busy", 64'(lat > 0), 64'd1);
    check("rd4_value", 64'(ref_mem[1]), 64'd1);
    rd_check("rd8_hit", 32'h8, lat);
    check("rd8_latency", 64'(lat), 64'd0);
    check("rd8_value", 64'(ref_mem[2]), 64'd2);

    // write hit then immediate read hit
    wr(32'h4, 4'hf, 32'habcd_1234);
    rd_check("wr_then_rd", 32'h4, lat);
    check("wr_then_rd_latency", 64'(lat), 64'd0);
    check("wr_then_rd_value", 64'(ref_mem[1]), 64'habcd_1234);

    // byte strobes
    wr(32'h40, 4'hf, 32'h1122_3344);
    wr(32'h40, 4'b0101, 32'hAABB_CCDD);
    access(32'h40, 4'b0000, 32'h0, rd, rdy, lat);
    check("strobe_ready", 64'(rdy), 64'd1);
    check("strobe_data", 64'(rd), 64'h11BB_33DD);

    // conflict miss on dirty line 0 (tag 0) by tag 1
    base = cmd_log.size();
    rd_check("conflict", 32'h84, lat);
    check("conflict_cmds", 64'(cmd_log.size() - base), 64'd2);
    if (cmd_log.size() - base == 2) begin
      check("conflict_wb_cmd", 64'(cmd_log[base]), 64'({1'b1, 10'd0}));
      check("conflict_rd_cmd", 64'(cmd_log[base + 1]), 64'({1'b0, 10'd16}));
      check("conflict_wb_len", 64'(cyc_log[base + 1] - cyc_log[base]), 64'd4);
    end
    for (int k = 0; k < 4; k++)
      check("wb_ram_line", ram[k], {ref_mem[2 * k + 1], ref_mem[2 * k]});
    base = cmd_log.size();
    rd_check("refetch", 32'h4, lat);
    check("refetch_value", 64'(ref_mem[1]), 64'habcd_1234);
    check("refetch_cmds", 64'(cmd_log.size() - base), 64'd1);
    if (cmd_log.size() - base == 1)
      check("refetch_rd_cmd", 64'(cmd_log[base]), 64'({1'b0, 10'd0}));

    // high address bits alias
    rd_check("alias", 32'h8000_2004, lat);
    check("alias_latency", 64'(lat), 64'd0);

    random_phase(300);

    // reset in the middle of a refill
    rd_check("pre_rst", 32'h20, lat);
    base = cmd_log.size();
    @(negedge clk);
    enable = 1'b1; address = 32'h2A0; write_enable = 4'b0000;
    found = 0;
    for (int n = 0; n < 60 && found == 0; n++) begin
      @(negedge clk);
      if (cmd_log.size() > base && cmd_log[cmd_log.size() - 1][10] == 1'b0) found = 1;
    end
    check("rst_rd_cmd_seen", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cmd_en", 64'(br_cmd_en), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_ready", 64'(data_out_ready), 64'd0);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    sync_ref_from_ram();
    base = cmd_log.size();
    rd_check("post_rst", 32'h2A0, lat);
    check("post_rst_missed", 64'(lat > 0), 64'd1);
    check("post_rst_cmds", 64'(cmd_log.size() - base), 64'd1);
    if (cmd_log.size() - base == 1)
      check("post_rst_rd_cmd", 64'(cmd_log[base]), 64'({1'b0, 10'd84}));

    random_phase(150);
    check("timeouts", 64'(timeouts), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
